// File: rtl/i2s_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : i2s_pkg
//  Brief    : Shared constants and buffer-state encoding for the I2S blocks
//  Revision : 1.0 - initial release
// ============================================================================
package i2s_pkg;

    // Default sample width; i2s_receive uses the same constant
    localparam int c_data_width = 24;
    // Default number of sck periods per channel slot
    localparam int c_slot_bits  = 32;

    // Input holding-buffer occupancy
    typedef enum logic [1:0] {
        BUF_EMPTY  = 2'd0,  // expecting a left beat
        BUF_HAVE_L = 2'd1,  // left held, expecting a right beat
        BUF_FULL   = 2'd2   // complete pair waiting for the next frame
    } buf_state_t;

endpackage
`default_nettype wire

// File: rtl/i2s_clkgen.sv
`default_nettype none
// ============================================================================
//  Module   : i2s_clkgen
//  Brief    : sck divider, falling-event strobe and frame bit counter k
//  Revision : 1.0 - initial release
// ============================================================================
module i2s_clkgen
    import i2s_pkg::*;
#(
    parameter int SCK_DIV   = 4,
    parameter int SLOT_BITS = c_slot_bits
) (
    input  logic                            clk,
    input  logic                            rst,
    output logic                            sck,
    output logic                            fall,
    output logic                            frame_start,
    output logic [$clog2(2*SLOT_BITS)-1:0]  k_next
);

    localparam int c_div_w = (SCK_DIV > 1) ? $clog2(SCK_DIV) : 1;
    localparam int c_k_w   = $clog2(2*SLOT_BITS);
    localparam logic [c_div_w-1:0] c_div_last = c_div_w'(SCK_DIV - 1);
    localparam logic [c_k_w-1:0]   c_k_last   = c_k_w'(2*SLOT_BITS - 1);

    logic [c_div_w-1:0] r_div_cnt;
    logic               r_sck;
    logic [c_k_w-1:0]   r_k;
    logic               w_tick;

    // sck toggles in the cycle the divider reaches its last count
    assign w_tick      = (r_div_cnt == c_div_last);
    assign fall        = w_tick && r_sck;
    // k wraps to 0 on this falling event: the frame starts here
    assign frame_start = fall && (r_k == c_k_last);
    assign k_next      = (r_k == c_k_last) ? '0 : r_k + 1'b1;
    assign sck         = r_sck;

    // Divider, bit clock and frame counter; k resets to its last value so the
    // first falling event after reset is a frame start
    always_ff @(posedge clk) begin
        if (rst) begin
            r_div_cnt <= '0;
            r_sck     <= 1'b0;
            r_k       <= c_k_last;
        end else begin
            if (w_tick) begin
                r_div_cnt <= '0;
                r_sck     <= ~r_sck;
            end else begin
                r_div_cnt <= r_div_cnt + 1'b1;
            end
            if (fall) begin
                r_k <= k_next;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/i2s_transmit.sv
`default_nettype none
// ============================================================================
//  Module   : i2s_transmit
//  Brief    : I2S master transmitter fed by an AXI-Stream slave port
//             (TLAST=1 marks the right-channel beat)
//  Revision : 1.0 - initial release
// ============================================================================
module i2s_transmit
    import i2s_pkg::*;
#(
    parameter int DATA_WIDTH = c_data_width,
    parameter int SLOT_BITS  = c_slot_bits,
    parameter int SCK_DIV    = 4
) (
    input  logic                  S_AXIS_ACLK,
    input  logic                  S_AXIS_ARESET,
    input  logic [DATA_WIDTH-1:0] S_AXIS_TDATA,
    input  logic                  S_AXIS_TVALID,
    input  logic                  S_AXIS_TLAST,
    output logic                  S_AXIS_TREADY,
    output logic                  sck,
    output logic                  ws,
    output logic                  sd,
    output logic                  underrun,
    output logic                  misalign
);

    localparam int c_k_w = $clog2(2*SLOT_BITS);

    buf_state_t            r_state;
    buf_state_t            w_state_next;
    logic                  w_hs;
    logic                  w_load_l;
    logic                  w_load_r;
    logic                  w_bad_beat;
    logic                  w_fall;
    logic                  w_frame_start;
    logic                  w_take;
    logic [c_k_w-1:0]      w_k_next;
    logic [c_k_w-1:0]      w_j;
    logic                  w_ws_next;
    logic                  w_sd_next;
    logic [DATA_WIDTH-1:0] w_word;
    logic [DATA_WIDTH-1:0] r_hold_l;
    logic [DATA_WIDTH-1:0] r_hold_r;
    logic [DATA_WIDTH-1:0] r_word_l;
    logic [DATA_WIDTH-1:0] r_word_r;
    logic                  r_ws;
    logic                  r_sd;
    logic                  r_underrun;
    logic                  r_misalign;

    i2s_clkgen #(
        .SCK_DIV   (SCK_DIV),
        .SLOT_BITS (SLOT_BITS)
    ) u_clkgen (
        .clk         (S_AXIS_ACLK),
        .rst         (S_AXIS_ARESET),
        .sck         (sck),
        .fall        (w_fall),
        .frame_start (w_frame_start),
        .k_next      (w_k_next)
    );

    // Ready is held low during reset so no beat is taken before the buffer is clean
    assign S_AXIS_TREADY = (r_state != BUF_FULL) && !S_AXIS_ARESET;
    assign w_hs          = S_AXIS_TVALID && S_AXIS_TREADY;
    assign w_take        = w_frame_start && (r_state == BUF_FULL);

    // Buffer state register
    always_ff @(posedge S_AXIS_ACLK) begin
        if (S_AXIS_ARESET) begin
            r_state <= BUF_EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Buffer next state: wrong-channel beats are swallowed and flagged
    always_comb begin
        w_state_next = r_state;
        w_load_l     = 1'b0;
        w_load_r     = 1'b0;
        w_bad_beat   = 1'b0;
        case (r_state)
            BUF_EMPTY: begin
                if (w_hs) begin
                    if (!S_AXIS_TLAST) begin
                        w_load_l     = 1'b1;
                        w_state_next = BUF_HAVE_L;
                    end else begin
                        w_bad_beat = 1'b1;
                    end
                end
            end
            BUF_HAVE_L: begin
                // A right beat landing on the frame-start cycle completes the
                // pair, which then waits for the following frame
                if (w_hs) begin
                    if (S_AXIS_TLAST) begin
                        w_load_r     = 1'b1;
                        w_state_next = BUF_FULL;
                    end else begin
                        w_bad_beat = 1'b1;
                    end
                end
            end
            BUF_FULL: begin
                if (w_frame_start) begin
                    w_state_next = BUF_EMPTY;
                end
            end
            default: w_state_next = BUF_EMPTY;
        endcase
    end

    // Serialiser: slot position j of the upcoming bit selects the data bit,
    // MSB at j=1, zeros at j=0 and past the sample
    always_comb begin
        w_ws_next = (w_k_next >= c_k_w'(SLOT_BITS));
        w_j       = w_ws_next ? (w_k_next - c_k_w'(SLOT_BITS)) : w_k_next;
        w_word    = w_ws_next ? r_word_r : r_word_l;
        w_sd_next = 1'b0;
        for (int b = 0; b < DATA_WIDTH; b++) begin
            if (w_j == c_k_w'(DATA_WIDTH - b)) begin
                w_sd_next = w_word[b];
            end
        end
    end

    // Holding registers, frame words, status flags and ws/sd output registers
    always_ff @(posedge S_AXIS_ACLK) begin
        if (S_AXIS_ARESET) begin
            r_hold_l   <= '0;
            r_hold_r   <= '0;
            r_word_l   <= '0;
            r_word_r   <= '0;
            r_ws       <= 1'b1;
            r_sd       <= 1'b0;
            r_underrun <= 1'b0;
            r_misalign <= 1'b0;
        end else begin
            r_underrun <= w_frame_start && !w_take;
            if (w_load_l) begin
                r_hold_l <= S_AXIS_TDATA;
            end
            if (w_load_r) begin
                r_hold_r <= S_AXIS_TDATA;
            end
            if (w_bad_beat) begin
                r_misalign <= 1'b1;
            end
            if (w_frame_start) begin
                r_word_l <= w_take ? r_hold_l : '0;
                r_word_r <= w_take ? r_hold_r : '0;
            end
            if (w_fall) begin
                r_ws <= w_ws_next;
                r_sd <= w_sd_next;
            end
        end
    end

    assign ws       = r_ws;
    assign sd       = r_sd;
    assign underrun = r_underrun;
    assign misalign = r_misalign;

endmodule
`default_nettype wire

// File: tb/tb_i2s_transmit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_i2s_transmit
//  Brief    : Self-checking bench for i2s_transmit; an I2S receiver model
//             decodes the line and frame contents are predicted from the
//             beat timestamps and the frame schedule
//  Revision : 1.0 - initial release
// ============================================================================
module tb_i2s_transmit;

    localparam int DW    = 24;
    localparam int SB    = 32;
    localparam int SD    = 2;
    localparam int P     = 10;
    localparam int FRAME = 2 * SB * 2 * SD;

    logic          clk    = 1'b0;
    logic          rst    = 1'b1;
    logic [DW-1:0] tdata  = '0;
    logic          tvalid = 1'b0;
    logic          tlast  = 1'b0;
    logic          tready;
    logic          sck;
    logic          ws;
    logic          sd;
    logic          underrun;
    logic          misalign;

    int  checks = 0;
    int  passes = 0;
    time tb     = 0;

    // Pairs handed to the DUT and the time their right beat was accepted
    logic [DW-1:0] pl[$];
    logic [DW-1:0] pr[$];
    time           pt[$];

    // Receiver-model state
    logic [DW-1:0] rx_l[$];
    logic [DW-1:0] rx_r[$];
    int            ur_cnt  = 0;
    int            pad_err = 0;
    int            m_j     = 0;
    logic          m_active   = 1'b0;
    logic          m_prev_sck = 1'b0;
    logic          m_prev_ws  = 1'b1;
    logic [DW-1:0] m_word = '0;
    logic [DW-1:0] m_left = '0;

    always #(P/2) clk = ~clk;

    i2s_transmit #(
        .DATA_WIDTH (DW),
        .SLOT_BITS  (SB),
        .SCK_DIV    (SD)
    ) dut (
        .S_AXIS_ACLK   (clk),
        .S_AXIS_ARESET (rst),
        .S_AXIS_TDATA  (tdata),
        .S_AXIS_TVALID (tvalid),
        .S_AXIS_TLAST  (tlast),
        .S_AXIS_TREADY (tready),
        .sck           (sck),
        .ws            (ws),
        .sd            (sd),
        .underrun      (underrun),
        .misalign      (misalign)
    );

    // Receiver model: samples sd on sck rise, the bit after a ws edge is j=0
    always @(negedge clk) begin
        if (rst) begin
            rx_l.delete();
            rx_r.delete();
            ur_cnt     = 0;
            pad_err    = 0;
            m_active   = 1'b0;
            m_prev_sck = 1'b0;
            m_prev_ws  = 1'b1;
            m_j        = 0;
            m_word     = '0;
            m_left     = '0;
        end else begin
            if (underrun === 1'b1) ur_cnt++;
            if (sck === 1'b1 && m_prev_sck == 1'b0) begin
                if (ws !== m_prev_ws) begin
                    m_active = 1'b1;
                    m_j      = 0;
                    m_word   = '0;
                end else begin
                    m_j++;
                end
                m_prev_ws = ws;
                if (m_active) begin
                    if (m_j >= 1 && m_j <= DW) m_word[DW - m_j] = sd;
                    else if (sd !== 1'b0) pad_err++;
                    if (m_j == SB - 1) begin
                        if (ws == 1'b0) m_left = m_word;
                        else begin
                            rx_l.push_back(m_left);
                            rx_r.push_back(m_word);
                        end
                    end
                end
            end
            m_prev_sck = sck;
        end
    end

    initial begin
        #(P * 40000);
        $display("FAIL watchdog: observed no finish, required finish before %0d", P * 40000);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_to(input time t);
        int n = 0;
        while ($time < t && n < 100000) begin
            @(negedge clk);
            n++;
        end
    endtask

    // Time of the frame-start clock edge of frame n after the last reset
    function automatic time e_time(input int n);
        return tb + time'((2 * SD + n * FRAME) * P);
    endfunction

    task automatic do_reset(input int n);
        sync();
        rst    = 1'b1;
        tvalid = 1'b0;
        repeat (n) @(posedge clk);
        tb = $time;
        #1;
        chk("rst_sck", sck, 0);
        chk("rst_ws", ws, 1);
        chk("rst_sd", sd, 0);
        chk("rst_tready", tready, 0);
        chk("rst_underrun", underrun, 0);
        chk("rst_misalign", misalign, 0);
        rst = 1'b0;
        pl.delete();
        pr.delete();
        pt.delete();
        #1;
        chk("rel_tready", tready, 1);
    endtask

    // First sck rise SCK_DIV cycles after release, first ws fall at 2*SCK_DIV
    task automatic check_startup();
        for (int c = 0; c <= 2 * SD; c++) begin
            wait_to(tb + time'(c * P + P / 2));
            if (c <= SD) chk($sformatf("start_sck_c%0d", c), sck, (c == SD) ? 1 : 0);
            if (c >= 2 * SD - 1) chk($sformatf("start_ws_c%0d", c), ws, (c == 2 * SD) ? 0 : 1);
        end
    endtask

    task automatic send(input logic [DW-1:0] d, input logic last, output time th);
        int   n  = 0;
        logic ok = 1'b0;
        tdata  = d;
        tlast  = last;
        tvalid = 1'b1;
        th     = 0;
        while (!ok && n < 2000) begin
            ok = tready;
            @(posedge clk);
            th = $time;
            n++;
            #1;
        end
        tvalid = 1'b0;
        chk("hs_timeout", ok, 1);
    endtask

    task automatic send_pair(input logic [DW-1:0] l, input logic [DW-1:0] r,
                             output time tl, output time tr);
        send(l, 1'b0, tl);
        send(r, 1'b1, tr);
        pl.push_back(l);
        pr.push_back(r);
        pt.push_back(tr);
    endtask

    // Frame n carries the oldest unsent pair completed strictly before its
    // frame-start edge, otherwise zeros with one underrun pulse
    task automatic check_frames(input string tag, input int nfr);
        int            ptr   = 0;
        int            zeros = 0;
        logic [DW-1:0] el, er, ol, orr;
        wait_to(e_time(nfr) - time'(P / 2));
        chk({tag, "_nframes"}, rx_l.size(), nfr);
        for (int n = 0; n < nfr; n++) begin
            if (ptr < pt.size() && pt[ptr] < e_time(n)) begin
                el = pl[ptr];
                er = pr[ptr];
                ptr++;
            end else begin
                el = '0;
                er = '0;
                zeros++;
            end
            ol  = (n < rx_l.size()) ? rx_l[n] : 24'hBADBAD;
            orr = (n < rx_r.size()) ? rx_r[n] : 24'hBADBAD;
            chk($sformatf("%s_f%0d_left", tag, n), ol, el);
            chk($sformatf("%s_f%0d_right", tag, n), orr, er);
        end
        chk({tag, "_underruns"}, ur_cnt, zeros);
        chk({tag, "_padding"}, pad_err, 0);
    endtask

    initial begin
        time tl, tr, tx;
        logic [DW-1:0] a, b;

        // Reset values, startup timing, then loopback of a fixed pair
        do_reset(5);
        check_startup();
        sync();
        send_pair(24'hABCDEF, 24'h123456, tl, tr);
        check_frames("loop", 3);

        // Back-pressure: four pairs queued back to back
        do_reset(5);
        for (int i = 0; i < 4; i++) begin
            a = DW'($urandom);
            b = DW'($urandom);
            send_pair(a, b, tl, tr);
            chk($sformatf("bp_ready_low_%0d", i), tready, 0);
            if (i > 0) begin
                chk($sformatf("bp_left_at_k0_%0d", i),
                    32'((((tl - tb) / P) - 2 * SD) % FRAME), 1);
                chk($sformatf("bp_right_next_%0d", i), 32'(tr - tl), P);
            end
        end
        check_frames("bp", 5);

        // Underrun: left only before frame start, right after it
        do_reset(5);
        send(24'h000001, 1'b0, tx);
        wait_to(e_time(0) + time'(3 * P + P / 2));
        chk("ur_first_pulse", ur_cnt, 1);
        sync();
        send(24'h000002, 1'b1, tr);
        pl.push_back(24'h000001);
        pr.push_back(24'h000002);
        pt.push_back(tr);
        check_frames("ur", 3);

        // Misalign: stray right first, stray left inside a pair
        do_reset(5);
        send(DW'($urandom), 1'b1, tx);
        chk("mis_set", misalign, 1);
        a = DW'($urandom);
        b = DW'($urandom);
        send(a, 1'b0, tx);
        send(DW'($urandom), 1'b0, tx);
        send(b, 1'b1, tr);
        pl.push_back(a);
        pr.push_back(b);
        pt.push_back(tr);
        check_frames("mis", 2);
        chk("mis_sticky", misalign, 1);

        // Mid-frame reset at k=40 drops buffered pairs
        do_reset(5);
        send_pair(DW'($urandom), DW'($urandom), tl, tr);
        send_pair(DW'($urandom), DW'($urandom), tl, tr);
        wait_to(e_time(0) + time'(40 * 2 * SD * P + P / 2));
        do_reset(1);
        check_startup();
        check_frames("midrst", 1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/i2s_transmit.md
# i2s_transmit

I2S master transmitter that produces the serial stream consumed by `i2s_receive`. It takes stereo samples from an AXI-Stream slave port, generates `sck` and `ws` from the system clock, and shifts each sample out MSB-first in standard I2S format. The block sits between the sample-processing fabric and the codec or loopback receiver. Its stream semantics match the receiver's stream output: `TLAST`=1 marks the right-channel beat.

## Interface
- `DATA_WIDTH`, 24: sample width in bits; must satisfy `DATA_WIDTH <= SLOT_BITS-1`.
- `SLOT_BITS`, 32: number of `sck` periods per channel slot.
- `SCK_DIV`, 4: `S_AXIS_ACLK` cycles per `sck` half-period; must be ≥2.
- `S_AXIS_ACLK` in 1: the only clock; every register in the block runs on its rising edge.
- `S_AXIS_ARESET` in 1: synchronous, active-high reset.
- `S_AXIS_TDATA` in DATA_WIDTH: sample data.
- `S_AXIS_TVALID` in 1: beat valid.
- `S_AXIS_TLAST` in 1: 0 = left sample, 1 = right sample.
- `S_AXIS_TREADY` out 1: the block can accept the current beat.
- `sck` out 1: I2S bit clock.
- `ws` out 1: word select; 0 = left slot, 1 = right slot.
- `sd` out 1: serial data.
- `underrun` out 1: one-cycle pulse when a frame starts without a complete sample pair buffered.
- `misalign` out 1: sticky flag, set when a beat arrives with the wrong channel; cleared only by reset.

## Operation
- **Clock divider.** `div_cnt` counts 0..SCK_DIV-1. When it reaches SCK_DIV-1, `sck` toggles and `div_cnt` wraps to 0.
  - A rising event is the cycle in which `sck` goes 0→1.
  - A falling event is the cycle in which `sck` goes 1→0.
  - All `ws` and `sd` updates occur only in the falling-event cycle. The receiver samples on the rising edge, so data is stable for a full half-period.
- **Frame counter.** `k` runs 0..2·SLOT_BITS-1 and advances once per falling event, wrapping to 0.
  - Slot index `j = k mod SLOT_BITS`.
  - `ws` is 0 for k<SLOT_BITS and 1 otherwise.
  - `ws` therefore changes at j=0, one bit period before the MSB.
- **Serial data.** `sd` = word[DATA_WIDTH-j] for 1≤j≤DATA_WIDTH; otherwise `sd` = 0.
  - word = left shift register when ws=0, right shift register when ws=1.
- **Input buffer.** Two holding registers, `hold_l` and `hold_r`, each with a valid bit. The buffer states are:
  - EMPTY: `TREADY`=1; expecting left.
  - HAVE_L: `TREADY`=1; expecting right.
  - FULL: `TREADY`=0.
- **Buffer transitions.**
  - EMPTY + beat with TLAST=0 → `hold_l` loaded, state HAVE_L.
  - HAVE_L + beat with TLAST=1 → `hold_r` loaded, state FULL.
  - A beat with the wrong TLAST for the current state is accepted and discarded, `misalign` is set, and the state is unchanged.
- **Frame start.** At the falling event with k=0:
  - If FULL: copy `hold_l`/`hold_r` into the left/right shift registers and return the buffer to EMPTY in the same cycle.
  - Otherwise: load zeros into both shift registers, pulse `underrun` for one cycle, and leave the buffer untouched. A half-received pair stays in HAVE_L.
- **Simultaneous events.**
  - A handshake in the k=0 load cycle cannot occur, because `TREADY`=0 when FULL.
  - If the state is HAVE_L at k=0, a right beat accepted in that same cycle completes the pair. The pair is used at the next frame.

## Timing
- **Reset values** (the cycle after reset is sampled high):
  - `sck`=0, `ws`=1, `sd`=0, `div_cnt`=0.
  - `k`=2·SLOT_BITS-1, so the first falling event is a frame start and drives `ws` 1→0, giving the receiver a `ws` edge.
  - Buffer EMPTY, `TREADY`=0 while reset is asserted and 1 from the first cycle after, `underrun`=0, `misalign`=0.
- **First events after reset.** First rising event at cycle SCK_DIV; first falling event (frame start) at cycle 2·SCK_DIV.
- **Reset mid-frame.** Aborts immediately. Outputs return to reset values in the next cycle and buffered samples are dropped.
- **Latency.** A pair completed before the k=0 falling event is transmitted in that frame: its MSB is driven at the falling event with k=1. Otherwise it is transmitted in the following frame.
- **Rates.** Frame length is 2·SLOT_BITS·2·SCK_DIV clocks. Sustained throughput is one pair per frame.

## Structure
- **Shared package `i2s_pkg`:** default DATA_WIDTH and SLOT_BITS, plus the buffer state encodings (EMPTY, HAVE_L, FULL). `i2s_receive` uses the same width constant.
- **Sub-module `i2s_clkgen`:** divider, `sck` register, rising/falling event strobes, and frame counter `k`.
- **Top level:** buffer FSM and shift/serialiser.

## Test plan
- **Reset:** assert reset for 5 cycles → `sck`=0, `ws`=1, `sd`=0, `TREADY`=0 during reset; `TREADY`=1 the cycle after release; first `sck` rise exactly SCK_DIV cycles after release.
- **Loopback with `i2s_receive`** (DATA_WIDTH=24, SLOT_BITS=32, SCK_DIV=2): send left 0xABCDEF, right 0x123456 → receiver `data_left`=0xABCDEF and `data_right`=0x123456 one frame later; `sd` bits 25..31 of each slot are 0.
- **Back-pressure:** hold `TVALID`=1 with 4 pairs queued → `TREADY` drops after each right beat and rises in the k=0 cycle; exactly one pair is transmitted per frame (256 clocks at SCK_DIV=2); no loss.
- **Underrun:** send only left 0x000001 before frame start → `underrun` pulses once and the frame carries all zeros. Then send right 0x000002 → the next frame carries 0x000001/0x000002 and `underrun` stays 0.
- **Misalign:** send TLAST=1 first → beat consumed, `misalign`=1, state stays EMPTY. Then send a valid pair → the pair is transmitted correctly and `misalign` remains 1.
- **Mid-frame reset:** assert reset at k=40 → the next cycle shows `sck`=0, `ws`=1, `sd`=0, buffer EMPTY; after release, the first falling event is k=0.
